// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file.
// A one-entry writeback register holds the execute result for one cycle
// (or longer under stall) and then commits it to a 32 x 32-bit array.
// Two combinational read ports bypass from the pending entry so decode
// always sees the youngest value. Register 0 reads as zero and ignores writes.
module wb_regfile #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] reg_write_addr_i,
    input  logic              reg_write_en_i,
    input  logic [DATA_W-1:0] reg_write_data_i,
    input  logic              reg1_read_en_i,
    input  logic [ADDR_W-1:0] reg1_read_addr_i,
    input  logic              reg2_read_en_i,
    input  logic [ADDR_W-1:0] reg2_read_addr_i,
    output logic [DATA_W-1:0] reg1_data_o,
    output logic [DATA_W-1:0] reg2_data_o,
    output logic              wb_valid_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [31:0]       retire_count_o
);

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       retire_count;
    logic [DATA_W-1:0] regs [REG_NUM];
    logic              advance;

    // Flush forces the stage to move even while stalled.
    assign advance = flush_i | ~stall_i;

    // Commit the pending entry and load the next one whenever the stage advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid     <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            retire_count <= '0;
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (advance) begin
            if (wb_valid) begin
                if (wb_addr != '0) begin
                    regs[wb_addr] <= wb_data;
                end
                retire_count <= retire_count + 32'd1;
            end
            if (flush_i) begin
                wb_valid <= 1'b0;
                wb_addr  <= '0;
                wb_data  <= '0;
            end else begin
                wb_valid <= reg_write_en_i;
                wb_addr  <= reg_write_addr_i;
                wb_data  <= reg_write_data_i;
            end
        end
    end

    // Read port 1: disabled or r0 reads zero, pending entry wins over the array.
    always_comb begin
        reg1_data_o = '0;
        if (reg1_read_en_i && (reg1_read_addr_i != '0)) begin
            if (wb_valid && (wb_addr == reg1_read_addr_i)) begin
                reg1_data_o = wb_data;
            end else begin
                reg1_data_o = regs[reg1_read_addr_i];
            end
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        reg2_data_o = '0;
        if (reg2_read_en_i && (reg2_read_addr_i != '0)) begin
            if (wb_valid && (wb_addr == reg2_read_addr_i)) begin
                reg2_data_o = wb_data;
            end else begin
                reg2_data_o = regs[reg2_read_addr_i];
            end
        end
    end

    assign wb_valid_o     = wb_valid;
    assign wb_addr_o      = wb_addr;
    assign wb_data_o      = wb_data;
    assign retire_count_o = retire_count;

endmodule
